// File: rtl/uart_pkg.sv
// Shared types and frame-format decode for the UART transmit path.
// Pure declarations; no timing or flow-control behaviour of its own.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  // data_bits 00..11 selects 5..8 bits; mask keeps only the bits sent on the line
  function automatic logic [7:0] data_mask(input logic [1:0] data_bits);
    return 8'hFF >> (2'd3 - data_bits);
  endfunction

  // Index of the final data bit (N-1) for a given data_bits code
  function automatic logic [2:0] last_data_idx(input logic [1:0] data_bits);
    return {1'b1, data_bits};
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with flush; read data is the combinational head entry.
// Write takes effect next cycle; a write at full is accepted only alongside a read.
module uart_sync_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty,
  output logic                          full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // flush takes priority over any same-cycle write or read
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// Queued UART transmitter with run-time frame format; START begins the cycle after a start decision.
// Input stalls only when the FIFO is full and no frame is starting this cycle.
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int DATA_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_en,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          flush,
  input  logic                          s_valid,
  input  logic [DATA_W-1:0]             s_data,
  output logic                          s_ready,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          frame_done
);

  tx_state_e         state, state_n;
  logic [DIV_W-1:0]  div_q, baud_cnt;
  logic [2:0]        bit_cnt;
  logic [1:0]        db_q;
  parity_e           pm_q;
  logic              two_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] head_masked;
  logic              start_ok, load, tick, last_data, last_stop, par_en;

  // A frame starting this cycle frees a slot, so a full FIFO can still take a byte
  assign s_ready     = !fifo_full || load;
  assign busy        = (state != IDLE);
  assign start_ok    = tx_en && !fifo_empty && (baud_div != '0);
  assign tick        = (baud_cnt == div_q - DIV_W'(1));
  assign last_data   = (bit_cnt == last_data_idx(db_q));
  assign last_stop   = (bit_cnt == {2'b00, two_q});
  assign par_en      = (pm_q == PAR_EVEN) || (pm_q == PAR_ODD);
  assign head_masked = head & data_mask(data_bits);

  uart_sync_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (s_valid && s_ready),
    .wr_data (s_data),
    .rd_en   (load),
    .rd_data (head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_n = START;
          load    = 1'b1;
        end
      end
      START:  if (tick) state_n = DATA;
      DATA:   if (tick && last_data) state_n = par_en ? PARITY : STOP;
      PARITY: if (tick) state_n = STOP;
      STOP: begin
        if (tick && last_stop) begin
          frame_done = 1'b1;
          if (start_ok) begin
            state_n = START;
            load    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx_out = 1'b1;
    case (state)
      START:   tx_out = 1'b0;
      DATA:    tx_out = shift_q[0];
      PARITY:  tx_out = par_q;
      default: tx_out = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      div_q    <= '0;
      db_q     <= '0;
      pm_q     <= PAR_NONE;
      two_q    <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        div_q    <= baud_div;
        db_q     <= data_bits;
        pm_q     <= parity_e'(parity_mode);
        two_q    <= two_stop;
        shift_q  <= head_masked;
        par_q    <= (^head_masked) ^ (parity_e'(parity_mode) == PAR_ODD);
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state != IDLE) begin
        if (tick) begin
          baud_cnt <= '0;
          // bit_cnt restarts whenever the frame moves to a new field
          bit_cnt  <= (state_n != state) ? 3'd0 : bit_cnt + 3'd1;
          if (state == DATA) shift_q <= shift_q >> 1;
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

endmodule
